// File: rtl/l1_train_sequencer.sv
// Replays stored digit samples into the L1 training layer as one-hot input spikes,
// pacing samples so the layer's post-spike update finishes before the next one.
module l1_train_sequencer #(
  parameter int unsigned p_s       = 25,
  parameter int unsigned p_ch_w    = 5,
  parameter int unsigned p_addr_w  = 12,
  parameter int unsigned p_samples = 100,
  parameter int unsigned p_epochs  = 16,
  parameter int unsigned p_gap     = 8,
  parameter int unsigned p_settle  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_gas_en,
  output logic                o_mem_rd,
  output logic [p_addr_w-1:0] o_mem_addr,
  input  logic [p_ch_w:0]     i_mem_data,
  output logic [p_s-1:0]      o_syncout,
  output logic                o_gas,
  output logic                o_endof_epochs,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [15:0]         o_sample_cnt,
  output logic [15:0]         o_epoch_cnt
);

  localparam int unsigned CntMax     = (p_gap > p_settle) ? p_gap : p_settle;
  localparam int unsigned CntW       = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned GapLast    = (p_gap > 0) ? p_gap - 1 : 0;
  localparam int unsigned SettleLast = p_settle - 1;
  localparam int unsigned SampLast   = p_samples - 1;
  localparam int unsigned EpochLast  = p_epochs - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EMIT   = 3'd2,
    S_GAP    = 3'd3,
    S_SETTLE = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e              state_q;
  logic [p_addr_w-1:0] addr_q;
  logic [CntW-1:0]     cnt_q;
  logic                first_q;
  logic                mem_rd_q;
  logic [p_s-1:0]      syncout_q;
  logic                gas_q;
  logic                eoe_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [15:0]         scnt_q;
  logic [15:0]         ecnt_q;

  // Event decode: channel c fires bit c-1; channel 0 is the null event.
  logic [p_ch_w-1:0]   ch_d;
  logic                eos_d;
  logic                ch_ok_d;
  logic                ch_bad_d;
  logic [p_s-1:0]      onehot_d;
  logic [p_addr_w-1:0] addr_inc_d;

  assign ch_d       = i_mem_data[p_ch_w-1:0];
  assign eos_d      = i_mem_data[p_ch_w];
  assign ch_ok_d    = (ch_d != '0) && (ch_d <= p_ch_w'(p_s));
  assign ch_bad_d   = (ch_d > p_ch_w'(p_s));
  assign onehot_d   = p_s'(1) << (ch_d - p_ch_w'(1));
  assign addr_inc_d = addr_q + p_addr_w'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      syncout_q <= '0;
      gas_q     <= 1'b0;
      eoe_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      scnt_q    <= '0;
      ecnt_q    <= '0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      syncout_q <= '0;
      mem_rd_q  <= 1'b0;
      done_q    <= 1'b0;
      if (i_abort) begin
        state_q <= S_IDLE;
        gas_q   <= 1'b0;
        busy_q  <= 1'b0;
        eoe_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              state_q  <= S_FETCH;
              addr_q   <= '0;
              scnt_q   <= '0;
              ecnt_q   <= '0;
              err_q    <= 1'b0;
              eoe_q    <= 1'b0;
              first_q  <= 1'b1;
              mem_rd_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
          S_FETCH: begin
            if (first_q) begin
              gas_q <= i_gas_en;
            end
            first_q <= 1'b0;
            state_q <= S_EMIT;
          end
          S_EMIT: begin
            if (ch_ok_d) begin
              syncout_q <= onehot_d;
            end
            if (ch_bad_d) begin
              err_q <= 1'b1;
            end
            cnt_q <= '0;
            if (eos_d) begin
              state_q <= S_SETTLE;
            end else if (p_gap == 0) begin
              state_q  <= S_FETCH;
              addr_q   <= addr_inc_d;
              mem_rd_q <= 1'b1;
            end else begin
              state_q <= S_GAP;
            end
          end
          S_GAP: begin
            if (cnt_q == CntW'(GapLast)) begin
              state_q  <= S_FETCH;
              addr_q   <= addr_inc_d;
              mem_rd_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          S_SETTLE: begin
            // Reward level drops as the sample's update window closes.
            if (cnt_q == CntW'(SettleLast)) begin
              state_q <= S_NEXT;
              gas_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          S_NEXT: begin
            first_q <= 1'b1;
            if (scnt_q < 16'(SampLast)) begin
              state_q  <= S_FETCH;
              addr_q   <= addr_inc_d;
              scnt_q   <= scnt_q + 16'd1;
              mem_rd_q <= 1'b1;
            end else begin
              addr_q <= '0;
              scnt_q <= '0;
              if (ecnt_q < 16'(EpochLast)) begin
                state_q  <= S_FETCH;
                ecnt_q   <= ecnt_q + 16'd1;
                mem_rd_q <= 1'b1;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                eoe_q   <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_mem_rd       = mem_rd_q;
  assign o_mem_addr     = addr_q;
  assign o_syncout      = syncout_q;
  assign o_gas          = gas_q;
  assign o_endof_epochs = eoe_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_sample_cnt   = scnt_q;
  assign o_epoch_cnt    = ecnt_q;

endmodule

// File: tb/tb_l1_train_sequencer.sv
// Scoreboard bench for l1_train_sequencer: a sample-walk model predicts reads, pulses and done.
module tb_l1_train_sequencer;

  localparam int PS    = 25;
  localparam int PCW   = 5;
  localparam int PAW   = 4;
  localparam int PSMP  = 4;
  localparam int PEP   = 2;
  localparam int PGAP  = 2;
  localparam int PSET  = 8;
  localparam int DEPTH = 1 << PAW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           gas_en = 1'b0;
  logic           mem_rd;
  logic [PAW-1:0] mem_addr;
  logic [PCW:0]   mem_data = '0;
  logic [PS-1:0]  syncout;
  logic           gas;
  logic           eoe;
  logic           busy;
  logic           done;
  logic           err;
  logic [15:0]    scnt;
  logic [15:0]    ecnt;

  l1_train_sequencer #(
    .p_s(PS), .p_ch_w(PCW), .p_addr_w(PAW), .p_samples(PSMP),
    .p_epochs(PEP), .p_gap(PGAP), .p_settle(PSET)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_gas_en(gas_en), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_data(mem_data), .o_syncout(syncout), .o_gas(gas),
    .o_endof_epochs(eoe), .o_busy(busy), .o_done(done), .o_err(err),
    .o_sample_cnt(scnt), .o_epoch_cnt(ecnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event memory: synchronous read, data valid the cycle after the strobe.
  logic [PCW:0] mem [DEPTH];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  typedef struct { int cyc; int addr; } rd_exp_t;
  typedef struct { int cyc; int bitn; bit gas; int scnt; int ecnt; } pl_exp_t;
  typedef struct { bit first; bit gas; } gas_plan_t;

  rd_exp_t   rd_q[$];
  pl_exp_t   pl_q[$];
  int        done_q[$];
  gas_plan_t gas_q[$];
  bit        exp_err;
  int        checks = 0;
  int        failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: DUT event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  task automatic flush();
    rd_q.delete();
    pl_q.delete();
    done_q.delete();
    gas_q.delete();
  endtask

  task automatic fill_mem(input bit allow_bad);
    int ch;
    for (int i = 0; i < DEPTH; i++) begin
      ch = allow_bad ? int'($urandom_range(0, 31)) : int'($urandom_range(1, PS));
      mem[i] = {($urandom_range(0, 2) == 0), PCW'(ch)};
    end
    mem[DEPTH-1][PCW] = 1'b1;
  endtask

  // Walk the memory sample by sample; each event costs 2+gap cycles, each sample end settle+3.
  task automatic plan_run(input int s_edge);
    int t;
    int a;
    int ch;
    bit eos;
    bit g;
    bit first;
    bit e_err;
    t = s_edge;
    a = 0;
    e_err = 1'b0;
    for (int ep = 0; ep < PEP; ep++) begin
      for (int sm = 0; sm < PSMP; sm++) begin
        g = 1'($urandom_range(0, 1));
        first = 1'b1;
        eos = 1'b0;
        while (!eos) begin
          ch = int'(mem[a][PCW-1:0]);
          eos = mem[a][PCW];
          rd_q.push_back('{cyc: t, addr: a});
          gas_q.push_back('{first: first, gas: g});
          first = 1'b0;
          if (ch >= 1 && ch <= PS)
            pl_q.push_back('{cyc: t + 2, bitn: ch - 1, gas: g, scnt: sm, ecnt: ep});
          else if (ch > PS)
            e_err = 1'b1;
          if (!eos) begin
            t += 2 + PGAP;
            a = (a + 1) % DEPTH;
          end
        end
        t += 2 + PSET + 1;
        a = (sm == PSMP - 1) ? 0 : (a + 1) % DEPTH;
      end
    end
    done_q.push_back(t);
    exp_err = e_err;
  endtask

  // Monitor: pops the scoreboard whenever the DUT reads, pulses or finishes.
  rd_exp_t m_r;
  pl_exp_t m_p;
  int      m_d;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        if (rd_q.size() == 0) unexpected("mem_rd");
        else begin
          m_r = rd_q.pop_front();
          chk("rd_cycle", cyc, m_r.cyc);
          chk("rd_addr", mem_addr, m_r.addr);
        end
      end
      if (syncout != '0) begin
        if (pl_q.size() == 0) unexpected("syncout");
        else begin
          m_p = pl_q.pop_front();
          chk("pulse_cycle", cyc, m_p.cyc);
          chk("pulse_bits", syncout, longint'(1) << m_p.bitn);
          chk("pulse_gas", gas, m_p.gas);
          chk("pulse_sample_cnt", scnt, m_p.scnt);
          chk("pulse_epoch_cnt", ecnt, m_p.ecnt);
        end
      end
      if (done) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          m_d = done_q.pop_front();
          chk("done_cycle", cyc, m_d);
          chk("done_eoe", eoe, 1);
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  // Gas driver: planned level on a sample's first read, noise on every other cycle.
  gas_plan_t g_p;
  always @(negedge clk) begin
    if (rst_n && mem_rd && gas_q.size() != 0) begin
      g_p = gas_q.pop_front();
      gas_en = g_p.first ? g_p.gas : 1'($urandom_range(0, 1));
    end else begin
      gas_en = 1'($urandom_range(0, 1));
    end
  end

  task automatic start_run();
    @(negedge clk);
    plan_run(cyc + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_eoe_clear", eoe, 0);
    chk("start_err_clear", err, 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_q.size() != 0) begin
      unexpected("done_timeout");
      flush();
    end
  endtask

  task automatic end_checks();
    repeat (3) @(negedge clk);
    chk("end_eoe_hold", eoe, 1);
    chk("end_busy", busy, 0);
    chk("end_sample_cnt", scnt, 0);
    chk("end_epoch_cnt", ecnt, PEP - 1);
    chk("end_err", err, exp_err);
    chk("end_rd_left", rd_q.size(), 0);
    chk("end_pulse_left", pl_q.size(), 0);
  endtask

  task automatic wait_pulse(input int s, input bit odd_addr, output bit found);
    int n;
    n = 0;
    found = 1'b0;
    while (n < 3000 && !found) begin
      @(negedge clk);
      if (syncout != '0 && scnt == 16'(s) && mem_addr[0] == odd_addr) found = 1'b1;
      n++;
    end
    if (!found) unexpected("pulse_wait_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_syncout", syncout, 0);
    chk("rst_gas", gas, 0);
    chk("rst_eoe", eoe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sample_cnt", scnt, 0);
    chk("rst_epoch_cnt", ecnt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sample 0 opens with channels 3, 7, 25 (eos).
    fill_mem(1'b0);
    mem[0] = {1'b0, PCW'(3)};
    mem[1] = {1'b0, PCW'(7)};
    mem[2] = {1'b1, PCW'(25)};
    start_run();
    wait_done(3000);
    end_checks();

    // Null and out-of-range channels inside the first sample.
    fill_mem(1'b1);
    mem[0] = {1'b0, PCW'(0)};
    mem[1] = {1'b0, PCW'(30)};
    start_run();
    wait_done(3000);
    end_checks();

    // Clean run must clear the sticky error; then a few fully random runs.
    for (int r = 0; r < 4; r++) begin
      fill_mem(r[0]);
      start_run();
      wait_done(3000);
      end_checks();
    end

    // Abort in the gap after the first event of sample 2.
    for (int i = 0; i < DEPTH; i++) mem[i] = {i[0], PCW'($urandom_range(1, PS))};
    start_run();
    wait_pulse(2, 1'b0, found);
    if (found) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_syncout", syncout, 0);
      chk("abort_gas", gas, 0);
      chk("abort_mem_rd", mem_rd, 0);
      chk("abort_sample_cnt", scnt, 2);
      chk("abort_epoch_cnt", ecnt, 0);
    end
    flush();
    repeat (6) @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    start_run();
    wait_done(3000);
    end_checks();

    // Asynchronous reset while settling after sample 1.
    start_run();
    wait_pulse(1, 1'b1, found);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_syncout", syncout, 0);
    chk("arst_gas", gas, 0);
    chk("arst_mem_rd", mem_rd, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_sample_cnt", scnt, 0);
    chk("arst_eoe", eoe, 0);
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_stays_idle", busy, 0);
    chk("arst_no_eoe", eoe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
